// File: rtl/load_store_unit_pkg.sv
// lsu_encoding: shared encodings for the load/store unit.
// RV32I funct3 values for loads/stores, the LSU state type, and a
// legality helper for funct3 that both the aligner and the top use.
package lsu_encoding;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_t;

  // Stores only have SB/SH/SW; loads reject the unused encodings 3, 6 and 7.
  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we)
      return (f3 > F3_W);
    else
      return (f3 == 3'd3) || (f3 >= 3'd6);
  endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// lsu_align: purely combinational lane handling for the LSU.
// Request side: byte enables, store lane replication, misalign/illegal check.
// Response side: shift the read word down by the byte offset and extend.
import lsu_encoding::*;

module lsu_align (
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        bad,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic        misalign;
  logic [31:0] sh;

  // Request-side decode; funct3[1:0] selects access size (BU/HU share B/H sizes).
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = off[0];
      end
      2'b10: begin
        misalign  = (off != 2'b00);
      end
      default: ;
    endcase
    bad = f3_illegal(we, funct3) | misalign;
  end

  // Response-side extraction with sign or zero extension.
  always_comb begin
    sh = rdata >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_B:    rdata_ext = {{24{sh[7]}}, sh[7:0]};
      F3_H:    rdata_ext = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   rdata_ext = {24'h000000, sh[7:0]};
      F3_HU:   rdata_ext = {16'h0000, sh[15:0]};
      default: rdata_ext = sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I memory-access stage on a req/gnt/rvalid bus.
// Optional bus timeout is compiled in with `define LSU_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | ready for a new access
// S_REQ  | mem_req high, waiting for mem_gnt
// S_WAIT | granted, waiting for mem_rvalid (load data or store ack)
// S_RESP | one-cycle resp_valid pulse to writeback
import lsu_encoding::*;

module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  lsu_state_t  state_q, state_d;
  logic        accept;
  logic        bad;
  logic        timeout;
  logic        abort;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] rdata_ext;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  lsu_align u_align (
    .we        (req_we),
    .funct3    (req_funct3),
    .off       (req_addr[1:0]),
    .wdata     (req_wdata),
    .be        (be_c),
    .wdata_rep (wdata_c),
    .bad       (bad),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .rdata     (mem_rdata),
    .rdata_ext (rdata_ext)
  );

  assign accept = (state_q == S_IDLE) && req_valid;

`ifdef LSU_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q;

  // Down-counter loaded on entry to S_REQ; terminal count means the budget is spent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmr_q <= '0;
    else if (accept && !bad)
      tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
    else if ((state_q == S_REQ || state_q == S_WAIT) && tmr_q != '0)
      tmr_q <= tmr_q - 1'b1;
  end

  assign timeout = (tmr_q == '0);
`else
  // Without the timer the timeout length has no meaning; tie it off.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // A late rvalid still wins over the timeout; a late gnt does not.
  assign abort = timeout &&
                 ((state_q == S_REQ) || (state_q == S_WAIT && !mem_rvalid));

  // State register; reset discards any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_req    = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_d = bad ? S_RESP : S_REQ;
      end
      S_REQ: begin
        mem_req = 1'b1;
        if (abort)
          state_d = S_RESP;
        else if (mem_gnt)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid || abort)
          state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture request fields at accept and the response at completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        mem_we     <= req_we;
        mem_addr   <= {req_addr[31:2], 2'b00};
        mem_be     <= be_c;
        mem_wdata  <= wdata_c;
        f3_q       <= req_funct3;
        off_q      <= req_addr[1:0];
        resp_rdata <= '0;
        resp_err   <= bad;
      end else if (state_q == S_WAIT && mem_rvalid) begin
        resp_rdata <= mem_we ? 32'h0 : rdata_ext;
        resp_err   <= 1'b0;
      end else if (abort) begin
        resp_rdata <= '0;
        resp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected responses are queued when an
// access is issued and compared when resp_valid pulses.
module tb_load_store_unit;
  import lsu_encoding::*;

`ifdef LSU_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 16;
`endif

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every response pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && resp_valid === 1'b1) begin
      check("resp_expected", {31'b0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'b0, resp_err}, {31'b0, e.err});
      end
    end
  end

  // One access from the IDLE negedge through the response; gnt after gnt_wait stall cycles.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input int gnt_wait, input string tag);
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    sb.push_back(exp_t'{rdata: exp_rdata, err: exp_err});
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    if (exp_err) begin
      check({tag, "_noreq"}, {31'b0, mem_req}, 32'd0);
      check({tag, "_resp_n1"}, {31'b0, resp_valid}, 32'd1);
      @(negedge clk);
      check({tag, "_noreq2"}, {31'b0, mem_req}, 32'd0);
      check({tag, "_resp_end"}, {31'b0, resp_valid}, 32'd0);
    end else begin
      for (int i = 0; i <= gnt_wait; i++) begin
        check({tag, "_mreq"}, {31'b0, mem_req}, 32'd1);
        check({tag, "_maddr"}, mem_addr, {addr[31:2], 2'b00});
        check({tag, "_mbe"}, {28'b0, mem_be}, {28'b0, exp_be});
        check({tag, "_mwe"}, {31'b0, mem_we}, {31'b0, we});
        if (we) check({tag, "_mwdata"}, mem_wdata, exp_wdata);
        check({tag, "_noresp"}, {31'b0, resp_valid}, 32'd0);
        if (i == gnt_wait) mem_gnt = 1'b1;
        @(negedge clk);
      end
      mem_gnt = 1'b0;
      check({tag, "_wait_mreq"}, {31'b0, mem_req}, 32'd0);
      check({tag, "_wait_noresp"}, {31'b0, resp_valid}, 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      check({tag, "_resp"}, {31'b0, resp_valid}, 32'd1);
      check({tag, "_resp_notready"}, {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      check({tag, "_resp_end"}, {31'b0, resp_valid}, 32'd0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = '0;
    req_wdata  = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'b0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_mem_we", {31'b0, mem_we}, 32'd0);
    check("rst_mem_be", {28'b0, mem_be}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    access(1'b0, F3_W,  32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0, 0, "lw");
    access(1'b0, F3_B,  32'h0000_0103, 32'h0, 32'h80FF_FF7F, 32'hFFFF_FF80, 1'b0, 4'b1000, 32'h0, 0, "lb");
    access(1'b0, F3_BU, 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 32'h0000_0080, 1'b0, 4'b1000, 32'h0, 0, "lbu");
    access(1'b0, F3_H,  32'h0000_0102, 32'h0, 32'h8001_0000, 32'hFFFF_8001, 1'b0, 4'b1100, 32'h0, 1, "lh");
    access(1'b0, F3_HU, 32'h0000_0102, 32'h0, 32'h8001_0000, 32'h0000_8001, 1'b0, 4'b1100, 32'h0, 0, "lhu");
    access(1'b1, F3_H,  32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'b1100, 32'hABCD_ABCD, 0, "sh");
    access(1'b1, F3_B,  32'h0000_0101, 32'h0000_005A, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'b0010, 32'h5A5A_5A5A, 2, "sb");
    access(1'b1, F3_W,  32'h0000_0300, 32'hCAFE_F00D, 32'h1234_5678, 32'h0, 1'b0, 4'b1111, 32'hCAFE_F00D, 0, "sw");
    access(1'b0, F3_W,  32'h0000_0101, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 0, "lw_misalign");
    access(1'b0, F3_H,  32'h0000_0103, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 0, "lh_misalign");
    access(1'b1, 3'd3,  32'h0000_0100, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 0, "st_illegal");
    access(1'b0, 3'd6,  32'h0000_0100, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 0, "ld_illegal");

`ifdef LSU_TIMEOUT_EN
    // gnt never arrives: request stays up for TO cycles, then an error response.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h0000_0400;
    sb.push_back(exp_t'{rdata: 32'h0, err: 1'b1});
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      check("tmo_mreq", {31'b0, mem_req}, 32'd1);
      check("tmo_maddr", mem_addr, 32'h0000_0400);
      @(negedge clk);
    end
    check("tmo_resp", {31'b0, resp_valid}, 32'd1);
    check("tmo_mreq_drop", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
`else
    access(1'b0, F3_W, 32'h0000_0400, 32'h0, 32'h1122_3344, 32'h1122_3344, 1'b0, 4'b1111, 32'h0, 5, "lw_stall");
    access(1'b1, F3_H, 32'h0000_0406, 32'hFFFF_9876, 32'h0, 32'h0, 1'b0, 4'b1100, 32'h9876_9876, 5, "sh_stall");
`endif

    // Reset while requesting: mem_req must drop without waiting for a clock.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F3_W;
    req_addr   = 32'h0000_0500;
    @(negedge clk);
    req_valid = 1'b0;
    check("rstreq_mreq_before", {31'b0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstreq_mreq", {31'b0, mem_req}, 32'd0);
    check("rstreq_ready", {31'b0, req_ready}, 32'd1);
    check("rstreq_maddr", mem_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset while waiting for data; the late rvalid must be ignored.
    req_valid  = 1'b1;
    req_addr   = 32'h0000_0600;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rstwait_busy", {31'b0, req_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    check("rstwait_ready", {31'b0, req_ready}, 32'd1);
    check("rstwait_mreq", {31'b0, mem_req}, 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stray_rvalid_noresp", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
    end

    // A normal access still completes after the aborted ones.
    access(1'b0, F3_W, 32'h0000_0700, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 4'b1111, 32'h0, 0, "lw_after_rst");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
